// File: rtl/pci_target_burst.sv
// 32-bit PCI memory target: DEPTH-word register file at BASE_ADDR with burst, byte-lane writes,
// initial wait states and disconnect at the window end. Define PCI_TARGET_WRAP_EN to wrap instead.
module pci_target_burst #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0010,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Clock,
  input  logic        RST,
  input  logic        Frame,
  inout  wire  [31:0] AddressData,
  input  logic [3:0]  CBE,
  input  logic        Irdy,
  output logic        Devsel,
  output logic        Trdy,
  output logic        Stop
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CmdMemRd = 4'b0110;
  localparam logic [3:0]  CmdMemWr = 4'b0111;
  localparam logic [2:0]  WrWait   = 3'(WAIT_STATES);
  // Reads always need at least one turnaround cycle before the target drives the bus.
  localparam logic [2:0]  RdWait   = (WAIT_STATES == 0) ? 3'd1 : 3'(WAIT_STATES);
  localparam logic [32:0] WinLo    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WinHi    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
`ifndef PCI_TARGET_WRAP_EN
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
`endif

  typedef enum logic [2:0] {
    StIdle,
    StIgnore,
    StWait,
    StData,
    StTurn,
    StDisc
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic              devsel_q, devsel_d;
  logic              trdy_q, trdy_d;
  logic              stop_q, stop_d;
  logic              ad_oe_q, ad_oe_d;

  logic              is_rd_cmd, is_mem_cmd, addr_hit;
  logic [2:0]        wait_len;
  logic [IdxW-1:0]   addr_idx;

  assign is_rd_cmd  = (CBE == CmdMemRd);
  assign is_mem_cmd = is_rd_cmd || (CBE == CmdMemWr);
  assign addr_hit   = ({1'b0, AddressData} >= WinLo) && ({1'b0, AddressData} < WinHi);
  assign addr_idx   = IdxW'((AddressData - BASE_ADDR) >> 2);
  assign wait_len   = is_rd_cmd ? RdWait : WrWait;

  // State register
  always_ff @(posedge Clock) begin
    if (RST) begin
      state_q  <= StIdle;
      cmd_rd_q <= 1'b0;
      idx_q    <= '0;
      wcnt_q   <= '0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cmd_rd_q <= cmd_rd_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      ad_oe_q  <= ad_oe_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cmd_rd_d = cmd_rd_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (!Frame && Irdy) begin
          if (is_mem_cmd && addr_hit) begin
            cmd_rd_d = is_rd_cmd;
            idx_d    = addr_idx;
            if (wait_len == 3'd0) begin
              state_d = StData;
            end else begin
              state_d = StWait;
              wcnt_d  = wait_len - 3'd1;
            end
          end else begin
            state_d = StIgnore;
          end
        end
      end
      StIgnore: begin
        if (Frame && Irdy) state_d = StIdle;
      end
      StWait: begin
        if (Frame && Irdy) begin
          state_d = StIdle;
        end else if (wcnt_q == 3'd0) begin
          state_d = StData;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      StData: begin
        if (Frame && Irdy) begin
          state_d = StIdle;
        end else if (!Irdy) begin
          // Trdy is low throughout StData, so Irdy low here is a completed transfer.
          if (!cmd_rd_q) begin
            for (int b = 0; b < 4; b++) begin
              if (!CBE[b]) mem_d[idx_q][8*b +: 8] = AddressData[8*b +: 8];
            end
          end
          idx_d = idx_q + 1'b1;
          if (Frame) begin
            state_d = StTurn;
          end
`ifndef PCI_TARGET_WRAP_EN
          else if (idx_q == LastIdx) begin
            state_d = StDisc;
          end
`endif
        end
      end
      StTurn: state_d = StIdle;
      StDisc: begin
        if (Frame) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the next state and registered
  always_comb begin
    devsel_d = 1'b1;
    trdy_d   = 1'b1;
    stop_d   = 1'b1;
    ad_oe_d  = 1'b0;
    unique case (state_d)
      StWait: devsel_d = 1'b0;
      StData: begin
        devsel_d = 1'b0;
        trdy_d   = 1'b0;
        ad_oe_d  = cmd_rd_d;
      end
      StDisc: begin
        devsel_d = 1'b0;
        stop_d   = 1'b0;
      end
      default: ;
    endcase
  end

  assign Devsel      = devsel_q;
  assign Trdy        = trdy_q;
  assign Stop        = stop_q;
  assign AddressData = ad_oe_q ? mem_q[idx_q] : 32'hz;

endmodule

// File: tb/tb_pci_target_burst.sv
// Bench for pci_target_burst: directed and randomized bursts checked against a word-array model.
module tb_pci_target_burst;

  localparam logic [31:0] BASE  = 32'h0000_0010;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, frame, irdy, ad_oe;
  logic [3:0]  cbe;
  logic [31:0] ad_drv;
  wire  [31:0] ad, ad2;
  logic        devsel, trdy, stop, devsel2, trdy2, stop2;
  logic        ad_released;

  assign ad  = ad_oe ? ad_drv : 32'hz;
  assign ad2 = ad_oe ? ad_drv : 32'hz;
  assign ad_released = (ad === 32'hzzzz_zzzz);

  always #5 clk = ~clk;

  pci_target_burst u_dut (
    .Clock(clk), .RST(rst), .Frame(frame), .AddressData(ad), .CBE(cbe), .Irdy(irdy),
    .Devsel(devsel), .Trdy(trdy), .Stop(stop)
  );

  pci_target_burst #(.WAIT_STATES(2)) u_dut_ws2 (
    .Clock(clk), .RST(rst), .Frame(frame), .AddressData(ad2), .CBE(cbe), .Irdy(irdy),
    .Devsel(devsel2), .Trdy(trdy2), .Stop(stop2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl  [DEPTH];
  logic [31:0] wdat [8];
  logic [3:0]  wbe  [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic release_bus();
    frame = 1'b1; irdy = 1'b1; ad_oe = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; frame = 1'b1; irdy = 1'b1; ad_oe = 1'b0; cbe = 4'hf; ad_drv = '0;
    tick();
    tick();
    chk("rst_devsel", devsel, 1'b1);
    chk("rst_trdy", trdy, 1'b1);
    chk("rst_stop", stop, 1'b1);
    chk("rst_ad_z", ad_released, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
    tick();
  endtask

  // One claimed memory transaction of n data phases with random Irdy stalls.
  task automatic burst(input logic [31:0] addr, input bit rd, input int n, input int max_stall);
    int idx;
    int cyc;
    idx = int'((addr - BASE) >> 2);
    frame = 1'b0; irdy = 1'b1; cbe = rd ? 4'b0110 : 4'b0111; ad_drv = addr; ad_oe = 1'b1;
    tick();
    ad_oe = !rd;
    #1;
    chk("devsel_claim", devsel, 1'b0);
    chk("trdy_first", trdy, rd ? 1'b1 : 1'b0);
    if (rd) chk("ad_turnaround_z", ad_released, 1'b1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_stall)) begin
        frame = 1'b0; irdy = 1'b1;
        tick();
      end
      irdy = 1'b0;
      frame = (i == n - 1);
      if (rd) begin
        cbe = 4'($urandom);
      end else begin
        ad_drv = wdat[i];
        cbe    = wbe[i];
      end
      cyc = 0;
      while (trdy !== 1'b0 && cyc < 8) begin
        tick();
        cyc++;
      end
      if (trdy !== 1'b0) begin
        chk("trdy_wait", trdy, 1'b0);
        release_bus();
        return;
      end
      if (rd) begin
        chk("rd_data", ad, mdl[idx]);
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (!wbe[i][b]) mdl[idx][8*b +: 8] = wdat[i][8*b +: 8];
        end
      end
      tick();
      idx++;
      if (i == n - 1) begin
        ad_oe = 1'b0;
        #1;
        chk("turn_devsel", devsel, 1'b1);
        chk("turn_trdy", trdy, 1'b1);
        chk("turn_stop", stop, 1'b1);
        chk("turn_ad_z", ad_released, 1'b1);
        frame = 1'b1; irdy = 1'b1;
        tick();
        return;
      end
      if (idx == DEPTH) begin
`ifdef PCI_TARGET_WRAP_EN
        idx = 0;
`else
        chk("disc_stop", stop, 1'b0);
        chk("disc_trdy", trdy, 1'b1);
        chk("disc_devsel", devsel, 1'b0);
        tick();
        chk("disc_hold_stop", stop, 1'b0);
        frame = 1'b1;
        tick();
        chk("disc_end_stop", stop, 1'b1);
        chk("disc_end_devsel", devsel, 1'b1);
        irdy = 1'b1; ad_oe = 1'b0;
        tick();
        return;
`endif
      end
      chk("trdy_next", trdy, 1'b0);
    end
  endtask

  task automatic unclaimed(input logic [31:0] addr, input logic [3:0] cmd);
    frame = 1'b0; irdy = 1'b1; cbe = cmd; ad_drv = addr; ad_oe = 1'b1;
    tick();
    chk("decode_devsel", devsel, 1'b1);
    irdy = 1'b0; frame = 1'b1; ad_drv = 32'hffff_ffff; cbe = 4'h0;
    tick();
    chk("decode_devsel_data", devsel, 1'b1);
    chk("decode_trdy", trdy, 1'b1);
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Three-word write at the window base, then read back.
    wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222; wdat[2] = 32'h3333_3333;
    for (int k = 0; k < 3; k++) wbe[k] = 4'b0000;
    burst(BASE, 1'b0, 3, 0);
    burst(BASE, 1'b1, 3, 0);

    // Burst starting at the last word runs into the window end.
    wdat[0] = 32'ha5a5_a5a5; wdat[1] = 32'hc3c3_c3c3; wdat[2] = 32'h9999_9999;
    burst(BASE + 32'hc, 1'b0, 3, 0);
    burst(BASE, 1'b1, DEPTH, 0);

    // Out-of-window addresses and a non-memory command are ignored.
    unclaimed(32'h0000_0004, 4'b0111);
    unclaimed(BASE + 32'(4 * DEPTH), 4'b0111);
    unclaimed(BASE, 4'b0010);

    // Master abort: claimed write dropped in its first phase, claimed read dropped in turnaround.
    frame = 1'b0; irdy = 1'b1; cbe = 4'b0111; ad_drv = BASE; ad_oe = 1'b1;
    tick();
    chk("abort_wr_devsel", devsel, 1'b0);
    frame = 1'b1; irdy = 1'b1; ad_drv = 32'hdead_beef; cbe = 4'h0;
    tick();
    chk("abort_wr_idle_devsel", devsel, 1'b1);
    chk("abort_wr_idle_trdy", trdy, 1'b1);
    frame = 1'b0; irdy = 1'b1; cbe = 4'b0110; ad_drv = BASE + 32'h8;
    tick();
    frame = 1'b1; irdy = 1'b1; ad_oe = 1'b0;
    tick();
    chk("abort_rd_devsel", devsel, 1'b1);
    chk("abort_rd_ad_z", ad_released, 1'b1);
    tick();
    burst(BASE, 1'b1, DEPTH, 0);

    // Reset arriving mid-burst after one transfer.
    frame = 1'b0; irdy = 1'b1; cbe = 4'b0111; ad_drv = BASE; ad_oe = 1'b1;
    tick();
    irdy = 1'b0; ad_drv = 32'hcafe_f00d; cbe = 4'h0;
    chk("rstmid_trdy", trdy, 1'b0);
    tick();
    rst = 1'b1; ad_drv = 32'hbadd_badd;
    tick();
    ad_oe = 1'b0;
    #1;
    chk("rstmid_devsel", devsel, 1'b1);
    chk("rstmid_trdy_hi", trdy, 1'b1);
    chk("rstmid_stop", stop, 1'b1);
    chk("rstmid_ad_z", ad_released, 1'b1);
    rst = 1'b0; frame = 1'b1; irdy = 1'b1;
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
    tick();
    burst(BASE, 1'b1, DEPTH, 0);

    // Byte lanes: one lane per phase starting at word 1.
    for (int k = 0; k < 4; k++) wdat[k] = 32'h3333_3333;
    wbe[0] = 4'b1110; wbe[1] = 4'b1101; wbe[2] = 4'b1011; wbe[3] = 4'b0111;
    burst(BASE + 32'h4, 1'b0, 4, 0);
    burst(BASE, 1'b1, DEPTH, 0);

    // Randomized write and read bursts with stalls.
    for (int r = 0; r < 8; r++) begin
      int s;
      int n;
      s = int'($urandom_range(DEPTH - 1));
      n = int'($urandom_range(5, 1));
      for (int k = 0; k < 8; k++) begin
        wdat[k] = $urandom;
        wbe[k]  = 4'($urandom);
      end
      burst(BASE + 32'(4 * s), 1'b0, n, 2);
      s = int'($urandom_range(DEPTH - 1));
      n = int'($urandom_range(5, 1));
      burst(BASE + 32'(4 * s), 1'b1, n, 2);
    end
    burst(BASE, 1'b1, DEPTH, 2);

    // Initial latency with two wait states against the zero-wait instance.
    do_reset();
    frame = 1'b0; irdy = 1'b1; cbe = 4'b0111; ad_drv = BASE; ad_oe = 1'b1;
    tick();
    chk("ws2_devsel", devsel2, 1'b0);
    chk("ws2_trdy_c1", trdy2, 1'b1);
    chk("ws0_trdy_c1", trdy, 1'b0);
    tick();
    chk("ws2_trdy_c2", trdy2, 1'b1);
    tick();
    chk("ws2_trdy_c3", trdy2, 1'b0);
    frame = 1'b1; irdy = 1'b0; ad_drv = 32'h5a5a_5a5a; cbe = 4'h0;
    tick();
    chk("ws2_turn_trdy", trdy2, 1'b1);
    chk("ws2_turn_devsel", devsel2, 1'b1);
    release_bus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pci_target_burst.md
Name: pci_target_burst

Overview:
- Parametrised successor to the single-target PCI slave: a 32-bit PCI memory target with a DEPTH-word register file at a programmable base address.
- Supports multi-word burst read/write, byte-lane writes, programmable initial latency and target disconnect (Stop) at the end of the window.
- Sits on the shared AddressData bus next to the existing PCI slave; driven by ClockGen's Clock.

Parameters:
- BASE_ADDR, 32'h0000_0010, byte address of word 0; low 2 bits must be 0.
- DEPTH, 4, number of 32-bit words; power of 2, 2..256.
- WAIT_STATES, 0, extra cycles (0..7) Trdy stays high before the first data phase.

Ports:
- Clock  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- Frame  input  1  PCI FRAME#, active-low.
- AddressData  inout  32  multiplexed address/data; driven only in read data state, else 32'hz.
- CBE  input  4  command in address phase; byte enables (active-low) in data phases.
- Irdy  input  1  initiator ready, active-low.
- Devsel  output  1  device select, active-low.
- Trdy  output  1  target ready, active-low.
- Stop  output  1  target stop request, active-low.

Behaviour:
- Reset: RST=1 at a rising edge gives state IDLE; Devsel=Trdy=Stop=1; AddressData released; all memory words 0; index 0.
- Reset mid-transaction aborts the transaction on that same edge. No partial write occurs in a cycle where RST=1.
- Address phase: in IDLE, sample Frame=0 and Irdy=1. The target claims the transaction only if both hold:
  - CBE=4'b0111 (mem write) or 4'b0110 (mem read);
  - BASE_ADDR <= AD < BASE_ADDR+4*DEPTH.
  - On a claim: latch cmd and index=(AD-BASE_ADDR)>>2, go to WAIT.
- Anything not claimed: stay in IGNORE until Frame=1 and Irdy=1 are sampled, then go to IDLE.
- WAIT:
  - Devsel=0 starting the cycle after the address phase.
  - A write waits WAIT_STATES cycles.
  - A read waits max(1, WAIT_STATES) cycles (turnaround), with AddressData released.
  - Then go to DATA.
- DATA:
  - Trdy=0. On a read, AddressData=mem[index].
  - A transfer happens at an edge where Irdy=0 and Trdy=0 are sampled together.
  - Write transfer: mem[index][8i+7:8i] is updated only for lanes with CBE[i]=0. CBE=4'b1111 writes nothing but still advances index.
  - Read transfer: CBE is ignored and all lanes are driven. The next word appears on the cycle after the transfer, with no added wait.
  - Irdy=1 stalls the phase: Trdy stays 0, data is held, index is held.
  - Each transfer does index+1.
- Last data phase: a transfer with Frame=1 sampled ends the transaction. Go to TURN: Devsel=Trdy=1 and AddressData released for one cycle, then IDLE.
- Window end: a transfer at index=DEPTH-1 with Frame=0 is a disconnect-with-data.
  - Go to DISC: Trdy=1, Stop=0, Devsel=0.
  - Hold until Frame=1 is sampled, then Stop=1 and Devsel=1, then IDLE.
  - If Frame=1 on that same transfer, take the normal end instead; Stop is never asserted.
- Master abort: in WAIT or DATA, Frame=1 with Irdy=1 sampled goes to IDLE on the next edge, with no transfer.
- Back-to-back transactions: a new address phase is accepted only from IDLE, so there is at least one idle cycle after TURN.
- All outputs are registered; no combinational path from the bus inputs to Devsel, Trdy or Stop.

Optional Feature:
- PCI_TARGET_WRAP_EN defined: index wraps DEPTH-1 to 0 and the burst continues; DISC and Stop are never entered (Stop held 1).
- PCI_TARGET_WRAP_EN undefined: disconnect at the window end as described in Behaviour.

Test Plan:
- Write burst, defaults:
  - Stimulus: addr 0x10, CBE=7, then data 11111111/22222222/33333333 with CBE=0000; Frame high on the third word.
  - Response: Devsel=0 one cycle after the address phase; mem[0..2] equals the three words; Trdy=1 after.
- Read-back:
  - Stimulus: addr 0x10, CBE=6, 3 phases.
  - Response: one turnaround cycle; AddressData gives 11111111, 22222222, 33333333 on the Trdy=0 cycles.
- Byte enables: write 0x33333333 to 0x14 in four phases, then read.
  - Undefined macro: with CBE=1110 on the first phase, mem[1] reads 0x00000033.
  - PCI_TARGET_WRAP_EN defined: with CBE=1110, 1101, 1011, 0111, mem[1] reads 0x00000033; mem[2]=0x00003300; mem[3]=0x00330000; mem[0]=0x33000000 (wrapped).
- Disconnect, undefined macro:
  - Stimulus: write start 0x1C, Frame held low for 3 phases.
  - Response: one transfer to mem[3], then Stop=0 and Trdy=1 until Frame=1; mem[0] unchanged.
- Decode and abort:
  - Stimulus: addr 0x04, cmd 7.
  - Response: Devsel stays 1, no memory change.
  - Stimulus: a claimed write where the master drops Frame and Irdy in WAIT.
  - Response: IDLE, no write.
- Reset:
  - Stimulus: RST=1 mid-burst after 1 transfer.
  - Response: Devsel=Trdy=Stop=1 on that edge; AddressData=z; all mem=0.
  - Check: a WAIT_STATES=2 instance shows Trdy=0 exactly 3 cycles after the address phase.
